// File: rtl/fa_using_ha_pkg.sv
// Shared constants and golden reference for the ripple full adder built from half adders.
package fa_using_ha_pkg;

    localparam int unsigned FA_WIDTH_DEFAULT = 1;
    localparam int unsigned FA_WIDTH_MAX     = 64;

    // Golden unsigned a+b+c at full 65-bit precision; callers truncate to WIDTH+1.
    function automatic logic [FA_WIDTH_MAX:0] fa_ref(
        input logic [FA_WIDTH_MAX-1:0] a,
        input logic [FA_WIDTH_MAX-1:0] b,
        input logic                    c
    );
        fa_ref = (FA_WIDTH_MAX + 1)'(a) + (FA_WIDTH_MAX + 1)'(b) + (FA_WIDTH_MAX + 1)'(c);
    endfunction

endpackage

// File: rtl/fa_using_ha_half_adder.sv
// Stateless half adder: sum and carry of two single bits.
module half_adder (
    input  logic x,
    input  logic y,
    output logic s,
    output logic co
);

    // Half-adder sum and carry
    assign s  = x ^ y;
    assign co = x & y;

endmodule

// File: rtl/fa_using_ha.sv
// WIDTH-bit ripple-carry adder; each slice is two half adders, all outputs registered.
// Optional build macro FA_USING_HA_OVF_EN adds a registered two's-complement overflow output ovf.
module fa_using_ha
    import fa_using_ha_pkg::*;
#(
    parameter int unsigned WIDTH = FA_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c,
    output logic [WIDTH-1:0] w1,
    output logic [WIDTH-1:0] w2,
    output logic [WIDTH-1:0] w3,
    output logic [WIDTH-1:0] sum,
    output logic             carry
`ifdef FA_USING_HA_OVF_EN
    ,
    output logic             ovf
`endif
);

    logic [WIDTH-1:0] ha1_s;
    logic [WIDTH-1:0] ha1_co;
    logic [WIDTH-1:0] ha2_s;
    logic [WIDTH-1:0] ha2_co;
    logic [WIDTH-1:0] cin;
    logic [WIDTH-1:0] cout;

    assign cin[0] = c;

    // Per-slice datapath: HA1 on the operands, HA2 folds in the rippled carry
    for (genvar i = 0; i < int'(WIDTH); i++) begin : g_slice
        half_adder u_ha1 (
            .x  (a[i]),
            .y  (b[i]),
            .s  (ha1_s[i]),
            .co (ha1_co[i])
        );

        half_adder u_ha2 (
            .x  (ha1_s[i]),
            .y  (cin[i]),
            .s  (ha2_s[i]),
            .co (ha2_co[i])
        );

        assign cout[i] = ha1_co[i] | ha2_co[i];

        if (i > 0) begin : g_ripple
            assign cin[i] = cout[i-1];
        end
    end

    // Capture every slice output and the final carry each cycle; reset clears all
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w1    <= '0;
            w2    <= '0;
            w3    <= '0;
            sum   <= '0;
            carry <= 1'b0;
        end else begin
            w1    <= ha1_s;
            w2    <= ha1_co;
            w3    <= ha2_co;
            sum   <= ha2_s;
            carry <= cout[WIDTH-1];
        end
    end

`ifdef FA_USING_HA_OVF_EN
    // Signed overflow: carry into the MSB differs from carry out of it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf <= 1'b0;
        end else begin
            ovf <= cin[WIDTH-1] ^ cout[WIDTH-1];
        end
    end
`endif

endmodule

// File: tb/tb_fa_using_ha.sv
// Bench for fa_using_ha at WIDTH=1, 8 and 16; honours FA_USING_HA_OVF_EN when defined.
module tb_fa_using_ha;
    import fa_using_ha_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic c   = 1'b0;

    logic [0:0]  a1 = '0, b1 = '0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic [15:0] a16 = '0, b16 = '0;

    logic [0:0]  w1_1, w2_1, w3_1, sum_1;
    logic [7:0]  w1_8, w2_8, w3_8, sum_8;
    logic [15:0] w1_16, w2_16, w3_16, sum_16;
    logic        carry_1, carry_8, carry_16;
`ifdef FA_USING_HA_OVF_EN
    logic        ovf_1, ovf_8, ovf_16;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    fa_using_ha #(.WIDTH(1)) u_w1 (
        .clk(clk), .rst(rst), .a(a1), .b(b1), .c(c),
        .w1(w1_1), .w2(w2_1), .w3(w3_1), .sum(sum_1), .carry(carry_1)
`ifdef FA_USING_HA_OVF_EN
        , .ovf(ovf_1)
`endif
    );

    fa_using_ha #(.WIDTH(8)) u_w8 (
        .clk(clk), .rst(rst), .a(a8), .b(b8), .c(c),
        .w1(w1_8), .w2(w2_8), .w3(w3_8), .sum(sum_8), .carry(carry_8)
`ifdef FA_USING_HA_OVF_EN
        , .ovf(ovf_8)
`endif
    );

    fa_using_ha #(.WIDTH(16)) u_w16 (
        .clk(clk), .rst(rst), .a(a16), .b(b16), .c(c),
        .w1(w1_16), .w2(w2_16), .w3(w3_16), .sum(sum_16), .carry(carry_16)
`ifdef FA_USING_HA_OVF_EN
        , .ovf(ovf_16)
`endif
    );

    task automatic check(input string name, input logic [64:0] act, input logic [64:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Concatenated view of every output of each DUT, all zero during reset
    function automatic logic [64:0] all_w1();
        logic [64:0] v;
        v = 65'({w1_1, w2_1, w3_1, sum_1, carry_1});
`ifdef FA_USING_HA_OVF_EN
        v = v | 65'(ovf_1);
`endif
        return v;
    endfunction

    function automatic logic [64:0] all_w8();
        logic [64:0] v;
        v = 65'({w1_8, w2_8, w3_8, sum_8, carry_8});
`ifdef FA_USING_HA_OVF_EN
        v = v | 65'(ovf_8);
`endif
        return v;
    endfunction

    function automatic logic [64:0] all_w16();
        logic [64:0] v;
        v = 65'({w1_16 | w2_16 | w3_16 | sum_16, carry_16});
`ifdef FA_USING_HA_OVF_EN
        v = v | 65'(ovf_16);
`endif
        return v;
    endfunction

    typedef struct {
        logic [2:0] abc;   // {a,b,c}
        logic [4:0] exp;   // {w1,w2,w3,sum,carry}
    } v1_t;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       c;
        logic [7:0] w1;
        logic [7:0] w2;
        logic [7:0] w3;
        logic [7:0] sum;
        logic       carry;
        logic       ovf;
    } v8_t;

    v1_t tab1 [8];
    v8_t tab8 [6];

    initial begin
        logic [64:0] r;

        // Hand-computed 1-bit truth table
        tab1[0] = '{3'b000, 5'b00000};
        tab1[1] = '{3'b001, 5'b00010};
        tab1[2] = '{3'b010, 5'b10010};
        tab1[3] = '{3'b011, 5'b10101};
        tab1[4] = '{3'b100, 5'b10010};
        tab1[5] = '{3'b101, 5'b10101};
        tab1[6] = '{3'b110, 5'b01001};
        tab1[7] = '{3'b111, 5'b01011};

        // Hand-computed 8-bit vectors
        tab8[0] = '{8'hFF, 8'h00, 1'b1, 8'hFF, 8'h00, 8'hFF, 8'h00, 1'b1, 1'b0};
        tab8[1] = '{8'h7F, 8'h01, 1'b0, 8'h7E, 8'h01, 8'h7E, 8'h80, 1'b0, 1'b1};
        tab8[2] = '{8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0};
        tab8[3] = '{8'hFF, 8'hFF, 1'b1, 8'h00, 8'hFF, 8'h00, 8'hFF, 1'b1, 1'b0};
        tab8[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 8'h80, 8'h00, 8'h00, 1'b1, 1'b1};
        tab8[5] = '{8'hA5, 8'h5A, 1'b0, 8'hFF, 8'h00, 8'h00, 8'hFF, 1'b0, 1'b0};

        // Reset held: toggle inputs, outputs stay zero
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            a1 = 1'(i); b1 = 1'(i >> 1); c = ~c;
            a8 = ~a8; b8 = 8'h5A; a16 = 16'hFFFF; b16 = 16'(i);
            @(posedge clk); #1;
            check("rst_hold_w1", all_w1(), 65'd0);
            check("rst_hold_w8", all_w8(), 65'd0);
            check("rst_hold_w16", all_w16(), 65'd0);
        end

        // First edge after reset captures 1+1+1
        @(negedge clk);
        rst = 1'b0;
        a1 = 1'b1; b1 = 1'b1; c = 1'b1;
        @(posedge clk); #1;
        check("post_rst_111", 65'({w1_1, w2_1, w3_1, sum_1, carry_1}), 65'(5'b01011));

        // WIDTH=1 exhaustive truth table
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            {a1, b1, c} = tab1[i].abc;
            @(posedge clk); #1;
            check($sformatf("tt1_%0d", i), 65'({w1_1, w2_1, w3_1, sum_1, carry_1}), 65'(tab1[i].exp));
            r = fa_ref(64'(a1), 64'(b1), c);
            check($sformatf("tt1_ref_%0d", i), 65'({carry_1, sum_1}), 65'(r[1:0]));
        end

        // WIDTH=8 directed vectors
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            a8 = tab8[i].a; b8 = tab8[i].b; c = tab8[i].c;
            @(posedge clk); #1;
            check($sformatf("v8_sum_%0d", i), 65'({carry_8, sum_8}), 65'({tab8[i].carry, tab8[i].sum}));
            check($sformatf("v8_w_%0d", i), 65'({w1_8, w2_8, w3_8}), 65'({tab8[i].w1, tab8[i].w2, tab8[i].w3}));
`ifdef FA_USING_HA_OVF_EN
            check($sformatf("v8_ovf_%0d", i), 65'(ovf_8), 65'(tab8[i].ovf));
`endif
        end

        // Async reset between edges discards the in-flight result
        @(negedge clk);
        a8 = 8'h12; b8 = 8'h34; c = 1'b0;
        @(posedge clk); #1;
        check("pre_async_sum", 65'(sum_8), 65'(8'h46));
        #2 rst = 1'b1;
        #1;
        check("async_rst_w8", all_w8(), 65'd0);
        check("async_rst_w1", all_w1(), 65'd0);
        rst = 1'b0;
        a8 = 8'h0F; b8 = 8'h01; c = 1'b1;
        @(posedge clk); #1;
        check("post_async_sum", 65'({carry_8, sum_8}), 65'(9'h011));
        check("post_async_w1", 65'(w1_8), 65'(8'h0E));

        // WIDTH=16 random vectors against the golden model
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            a16 = 16'($urandom); b16 = 16'($urandom); c = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            r = fa_ref(64'(a16), 64'(b16), c);
            check("rnd_sum", 65'({carry_16, sum_16}), 65'(r[16:0]));
            check("rnd_w2w3", 65'(w2_16 & w3_16), 65'd0);
            check("rnd_w1", 65'(w1_16), 65'(a16 ^ b16));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fa_using_ha.md
FA_USING_HA -- requirements
Module: fa_using_ha

Interface
- REQ-001: Parameter WIDTH SHALL default to 1 and is the number of full-adder bit slices; legal range is 1..64.
- REQ-002: clk  input  1  rising-edge clock for all state.
- REQ-003: rst  input  1  asynchronous, active-high reset.
- REQ-004: a  input  WIDTH  addend A.
- REQ-005: b  input  WIDTH  addend B.
- REQ-006: c  input  1  carry-in to bit 0.
- REQ-007: w1  output  WIDTH  registered first-half-adder sums, a[i]^b[i].
- REQ-008: w2  output  WIDTH  registered first-half-adder carries, a[i]&b[i].
- REQ-009: w3  output  WIDTH  registered second-half-adder carries, (a[i]^b[i])&cin[i].
- REQ-010: sum  output  WIDTH  registered sum bits.
- REQ-011: carry  output  1  registered carry-out of bit WIDTH-1.

Function
- REQ-012: Each bit slice i SHALL consist of two half adders: HA1(a[i],b[i]) and HA2(HA1.sum, cin[i]).
- REQ-013: Per slice: sum[i]=w1[i]^cin[i] and cout[i]=w2[i]|w3[i]; cin[0]=c and cin[i]=cout[i-1] (ripple).
- REQ-014: carry SHALL equal cout[WIDTH-1]; {carry,sum} SHALL equal a+b+c, unsigned, modulo 2^(WIDTH+1), which never wraps.
- REQ-015: All outputs SHALL be captured on every rising clk edge from the current a, b and c, giving a fixed latency of 1 cycle.
- REQ-016: There is no handshake and no enable; the inputs are sampled every cycle.
- REQ-017: w2[i] and w3[i] SHALL never both be 1 in the same slice.
- REQ-018: A full-carry chain, such as all-ones plus c=1, SHALL settle within one cycle, with no multicycle path permitted.

Reset
- REQ-019: While rst=1, w1, w2, w3, sum, carry and ovf (when present) SHALL be 0, immediately and independently of clk.
- REQ-020: If rst asserts mid-operation, the in-flight result SHALL be discarded.
- REQ-021: On the first rising clk edge after rst deasserts, the outputs SHALL capture the current inputs.

Configuration
- REQ-022: With macro FA_USING_HA_OVF_EN defined, an extra output ovf (1 bit, registered, 1-cycle latency, reset 0) SHALL equal cin[WIDTH-1]^cout[WIDTH-1], the two's-complement overflow.
- REQ-023: Without FA_USING_HA_OVF_EN, the ovf port and its logic SHALL be absent, and all other behaviour is identical.

Structure
- REQ-024: Package fa_using_ha_pkg SHALL hold the constant FA_WIDTH_DEFAULT=1, the constant FA_WIDTH_MAX=64 and the function fa_ref(a,b,c), which returns the WIDTH+1-bit golden sum for benches.
- REQ-025: A combinational sub-module half_adder (inputs x,y; outputs s=x^y, co=x&y) SHALL be instantiated twice per slice via a generate loop.
- REQ-026: Registers SHALL reside only in fa_using_ha; half_adder SHALL contain no state.

Verification
- REQ-027: WIDTH=1, hold rst=1, toggle a/b/c -> all outputs 0; then deassert and apply a=1,b=1,c=1 -> next cycle w1=0,w2=1,w3=0,sum=1,carry=1.
- REQ-028: WIDTH=1, exhaustive truth table over 8 combos with a toggling every 8 units, b every 4 and c every 2 -> e.g. a=0,b=1,c=1 gives w1=1,w2=0,w3=1,sum=0,carry=1, matching fa_ref one cycle later.
- REQ-029: WIDTH=8, a=8'hFF,b=8'h00,c=1 -> sum=8'h00, carry=1, w1=8'hFF, w3=8'hFF; ovf=0 when FA_USING_HA_OVF_EN.
- REQ-030: WIDTH=8 with FA_USING_HA_OVF_EN, a=8'h7F,b=8'h01,c=0 -> sum=8'h80, carry=0, ovf=1.
- REQ-031: Assert rst asynchronously between clk edges while sum is nonzero -> outputs 0 before the next edge, then the first post-reset edge reflects the inputs.
- REQ-032: 1000 random vectors at WIDTH=16 -> {carry,sum} equals fa_ref every cycle, w2&w3 is always 0, and w1=a^b delayed by 1 cycle.
